// File: rtl/cell_divergence_ctrl_if.sv
// Bundle between the cell sequencer and one cell's divergence controller.
// Carries instruction/consensus inputs, gating outputs, and local PC/SP debug taps.
interface cell_divergence_ctrl_if #(
  parameter int REGISTER_LENGTH = 8,
  parameter int PC_LENGTH       = 12,
  parameter int SP_LENGTH       = 5,
  parameter int DIV_CNT_WIDTH   = 8
) ();
  logic [REGISTER_LENGTH-1:0] target_value;
  logic [15:0]                instruction;
  logic [PC_LENGTH-1:0]       next_program_counter;
  logic [SP_LENGTH-1:0]       next_stack_pointer;
  logic                       execution_enable;

  logic                       enable;
  logic                       state_change_enable;
  logic                       diverge;
  logic [1:0]                 div_state;
  logic [DIV_CNT_WIDTH-1:0]   div_cycles;
  logic                       watchdog_err;
  logic [PC_LENGTH-1:0]       local_pc;
  logic [SP_LENGTH-1:0]       local_sp;

  // Handshake: no valid/ready. Inputs are sampled every cycle; enable, state_change_enable
  // and diverge are combinational from this cycle's inputs, all others are registered.
  modport master (
    output target_value, instruction, next_program_counter, next_stack_pointer,
           execution_enable,
    input  enable, state_change_enable, diverge, div_state, div_cycles, watchdog_err,
           local_pc, local_sp
  );

  modport slave (
    input  target_value, instruction, next_program_counter, next_stack_pointer,
           execution_enable,
    output enable, state_change_enable, diverge, div_state, div_cycles, watchdog_err,
           local_pc, local_sp
  );
endinterface

// File: rtl/cell_divergence_ctrl.sv
// Per-cell SIMT divergence controller: votes against branch consensus and tracks rejoin.
// Optional watchdog FAULT state is compiled in with `define CELL_DIV_WATCHDOG_EN.
module cell_divergence_ctrl #(
  parameter int REGISTER_LENGTH  = 8,
  parameter int PC_LENGTH        = 12,
  parameter int SP_LENGTH        = 5,
  parameter int BRANCH_ADDR_BITS = 8,
  parameter int DIV_CNT_WIDTH    = 8,
  parameter int WATCHDOG_LIMIT   = 200,
  parameter logic [3:0] OPC_UNL  = 4'hA,
  parameter logic [3:0] OPC_JUMP = 4'hB,
  parameter logic [3:0] OPC_CALL = 4'hC,
  parameter logic [3:0] OPC_RET  = 4'hD,
  parameter logic [3:0] REG_MY   = 4'hF
) (
  input logic                   clk,
  input logic                   rst,
  cell_divergence_ctrl_if.slave bus
);

  if (BRANCH_ADDR_BITS < 1 || BRANCH_ADDR_BITS > 12 ||
      WATCHDOG_LIMIT < 1 || WATCHDOG_LIMIT > (2 ** DIV_CNT_WIDTH) - 1) begin : g_bad_param
    $error("cell_divergence_ctrl: parameter out of range");
  end

`ifdef CELL_DIV_WATCHDOG_EN
  typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_DIVERGED = 2'd1, ST_FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_DIVERGED = 2'd1} state_t;
`endif

  localparam logic [DIV_CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                   state_q;
  logic [PC_LENGTH-1:0]     local_pc_q, rec_pc_q;
  logic [SP_LENGTH-1:0]     local_sp_q, rec_sp_q;
  logic [DIV_CNT_WIDTH-1:0] div_cycles_q, div_cycles_d;

  logic [3:0]           opcode, target;
  logic [PC_LENGTH-1:0] btarget;
  logic                 cond_fail, ujump, rejoin, diverge;

  assign opcode    = bus.instruction[15:12];
  assign target    = bus.instruction[11:8];
  assign btarget   = PC_LENGTH'(bus.instruction[BRANCH_ADDR_BITS-1:0]);
  assign cond_fail = (opcode == OPC_UNL) && (bus.target_value == '0);
  assign ujump     = (opcode == OPC_JUMP) || (opcode == OPC_CALL) || (opcode == OPC_RET);
  assign rejoin    = (bus.next_program_counter == rec_pc_q) &&
                     (bus.next_stack_pointer == rec_sp_q);

  // Any non-ACTIVE state keeps voting "diverge" so the rest of the array is never stalled.
  assign diverge      = (state_q == ST_ACTIVE) ? cond_fail : 1'b1;
  assign div_cycles_d = (div_cycles_q == CNT_MAX) ? div_cycles_q : div_cycles_q + 1'b1;

  assign bus.diverge             = diverge;
  assign bus.enable              = bus.execution_enable && !diverge && !ujump;
  assign bus.state_change_enable = bus.enable && (target == REG_MY);
  assign bus.div_state           = state_q;
  assign bus.div_cycles          = div_cycles_q;
  assign bus.local_pc            = local_pc_q;
  assign bus.local_sp            = local_sp_q;

`ifdef CELL_DIV_WATCHDOG_EN
  logic watchdog_err_q;
  assign bus.watchdog_err = watchdog_err_q;
`else
  assign bus.watchdog_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ACTIVE;
      local_pc_q     <= '0;
      local_sp_q     <= '0;
      rec_pc_q       <= '0;
      rec_sp_q       <= '0;
      div_cycles_q   <= '0;
`ifdef CELL_DIV_WATCHDOG_EN
      watchdog_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (cond_fail) begin
            local_pc_q <= btarget;
            if (bus.next_program_counter != btarget) begin
              rec_pc_q     <= btarget;
              rec_sp_q     <= local_sp_q;
              div_cycles_q <= '0;
              state_q      <= ST_DIVERGED;
            end
          end else begin
            local_pc_q <= bus.next_program_counter;
            local_sp_q <= bus.next_stack_pointer;
          end
        end
        ST_DIVERGED: begin
          // Rejoin is tested first so it wins over a coincident watchdog expiry.
          if (rejoin) begin
            state_q <= ST_ACTIVE;
          end else begin
            div_cycles_q <= div_cycles_d;
`ifdef CELL_DIV_WATCHDOG_EN
            if (div_cycles_d == DIV_CNT_WIDTH'(WATCHDOG_LIMIT)) begin
              state_q        <= ST_FAULT;
              watchdog_err_q <= 1'b1;
            end
`endif
          end
        end
`ifdef CELL_DIV_WATCHDOG_EN
        ST_FAULT: state_q <= ST_FAULT;
`endif
        default: state_q <= ST_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_divergence_ctrl.sv
// Directed bench for cell_divergence_ctrl; expected outputs are queued by the driver
// and compared by an independent negedge monitor.
module tb_cell_divergence_ctrl;
  localparam int RL = 8, PL = 12, SL = 5, BAB = 8, DW = 4, WDL = 10;
  localparam int W = 6 + DW;
  localparam logic [3:0] OP_ADD = 4'h1, OP_UNL = 4'hA, OP_JUMP = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC, OP_RET = 4'hD, R_MY = 4'hF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cell_divergence_ctrl_if #(.REGISTER_LENGTH(RL), .PC_LENGTH(PL), .SP_LENGTH(SL),
                            .DIV_CNT_WIDTH(DW)) bus ();

  cell_divergence_ctrl #(
    .REGISTER_LENGTH(RL), .PC_LENGTH(PL), .SP_LENGTH(SL), .BRANCH_ADDR_BITS(BAB),
    .DIV_CNT_WIDTH(DW), .WATCHDOG_LIMIT(WDL), .OPC_UNL(OP_UNL), .OPC_JUMP(OP_JUMP),
    .OPC_CALL(OP_CALL), .OPC_RET(OP_RET), .REG_MY(R_MY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] obs, exp_v;
  string        exp_n;

  assign obs = {bus.enable, bus.state_change_enable, bus.diverge, bus.div_state,
                bus.div_cycles, bus.watchdog_err};

  function automatic logic [W-1:0] ev(bit en, bit sce, bit dv, logic [1:0] st, int cyc, bit wd);
    return {en, sce, dv, st, DW'(cyc), wd};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      exp_n = name_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s: actual {en,sce,dv,st,cyc,wd}=%b required=%b", exp_n, obs, exp_v);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic [3:0] rg, input logic [7:0] imm,
                       input logic [7:0] tv, input logic [11:0] npc, input logic [4:0] nsp,
                       input bit ee);
    bus.instruction          = {op, rg, imm};
    bus.target_value         = tv;
    bus.next_program_counter = npc;
    bus.next_stack_pointer   = nsp;
    bus.execution_enable     = ee;
  endtask

  task automatic step(input bit r, input logic [3:0] op, input logic [3:0] rg,
                      input logic [7:0] imm, input logic [7:0] tv, input logic [11:0] npc,
                      input logic [4:0] nsp, input bit ee, input logic [W-1:0] e,
                      input string n);
    @(posedge clk);
    #1;
    rst = r;
    drive(op, rg, imm, tv, npc, nsp, ee);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Raises rst between clock edges; the monitor samples before the next rising edge.
  task automatic async_rst(input logic [3:0] op, input logic [3:0] rg, input logic [11:0] npc,
                           input logic [W-1:0] e, input string n);
    @(posedge clk);
    #1;
    drive(op, rg, 8'h00, 8'h05, npc, 5'd4, 1'b1);
    #2;
    rst = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    rst = 1'b1;
    drive(OP_ADD, 4'h2, 8'h00, 8'h00, 12'h000, 5'd0, 1'b0);

    // reset behaviour: outputs still follow the instruction, state pinned to ACTIVE
    step(1, OP_ADD, 4'h2, 8'h00, 8'h00, 12'h000, 5'd0, 1, ev(1,0,0,0,0,0), "rst_enable");
    step(1, OP_ADD, R_MY, 8'h00, 8'h05, 12'h000, 5'd0, 1, ev(1,1,0,0,0,0), "rst_sce");
    step(1, OP_UNL, 4'h1, 8'h20, 8'h00, 12'h005, 5'd0, 1, ev(0,0,1,0,0,0), "rst_cond_fail");

    // active operation
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h010, 5'd3, 1, ev(1,1,0,0,0,0), "add_my");
    step(0, OP_ADD, 4'h2, 8'h00, 8'h05, 12'h011, 5'd3, 1, ev(1,0,0,0,0,0), "add_other");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h012, 5'd4, 0, ev(0,0,0,0,0,0), "ee_low");
    step(0, OP_UNL, 4'h1, 8'h20, 8'h00, 12'h020, 5'd4, 1, ev(0,0,1,0,0,0), "unl_consensus");
    step(0, OP_ADD, 4'h1, 8'h00, 8'h00, 12'h021, 5'd4, 1, ev(1,0,0,0,0,0), "after_consensus");
    step(0, OP_UNL, 4'h1, 8'h20, 8'h07, 12'h022, 5'd4, 1, ev(1,0,0,0,0,0), "unl_nonzero");

    // divergence, sp mismatch, rejoin after 3 non-rejoin cycles
    step(0, OP_UNL, 4'h1, 8'h20, 8'h00, 12'h005, 5'd4, 1, ev(0,0,1,0,0,0), "unl_diverge");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h006, 5'd4, 1, ev(0,0,1,1,0,0), "div_c0");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h007, 5'd4, 1, ev(0,0,1,1,1,0), "div_c1");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h020, 5'd5, 1, ev(0,0,1,1,2,0), "div_sp_mismatch");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h020, 5'd4, 1, ev(0,0,1,1,3,0), "div_rejoin");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h021, 5'd4, 1, ev(1,1,0,0,3,0), "rejoined");
    step(0, OP_JUMP, R_MY, 8'h30, 8'h05, 12'h030, 5'd4, 1, ev(0,0,0,0,3,0), "jump");
    step(0, OP_CALL, R_MY, 8'h30, 8'h05, 12'h030, 5'd4, 1, ev(0,0,0,0,3,0), "call");
    step(0, OP_RET,  R_MY, 8'h30, 8'h05, 12'h030, 5'd4, 1, ev(0,0,0,0,3,0), "ret");
    step(0, OP_UNL, 4'h1, 8'h40, 8'h00, 12'h041, 5'd4, 1, ev(0,0,1,0,3,0), "unl_diverge2");

`ifdef CELL_DIV_WATCHDOG_EN
    for (int n = 0; n < 10; n++)
      step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h041, 5'd4, 1, ev(0,0,1,1,n,0), "wd_count");
    for (int k = 0; k < 3; k++)
      step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h040, 5'd4, 1, ev(0,0,1,2,10,1), "fault_hold");
    async_rst(OP_ADD, R_MY, 12'h040, ev(1,1,0,0,0,0), "rst_in_fault");
    step(0, OP_ADD, 4'h2, 8'h00, 8'h05, 12'h010, 5'd4, 1, ev(1,0,0,0,0,0), "post_fault");
    step(0, OP_UNL, 4'h1, 8'h40, 8'h00, 12'h041, 5'd4, 1, ev(0,0,1,0,0,0), "unl_diverge3");
    for (int n = 0; n < 9; n++)
      step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h041, 5'd4, 1, ev(0,0,1,1,n,0), "pre_limit");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h040, 5'd4, 1, ev(0,0,1,1,9,0), "rejoin_at_limit");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h050, 5'd4, 1, ev(1,1,0,0,9,0), "rejoin_won");
    step(0, OP_UNL, 4'h1, 8'h40, 8'h00, 12'h041, 5'd4, 1, ev(0,0,1,0,9,0), "unl_diverge4");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h041, 5'd4, 1, ev(0,0,1,1,0,0), "div4_c0");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h041, 5'd4, 1, ev(0,0,1,1,1,0), "div4_c1");
`else
    for (int n = 0; n <= 40; n++)
      step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h041, 5'd4, 1,
           ev(0,0,1,1,(n > 15) ? 15 : n,0), "sat_count");
`endif

    // async reset mid-divergence, then an unconditional jump
    async_rst(OP_ADD, 4'h2, 12'h041, ev(1,0,0,0,0,0), "rst_mid_div");
    step(0, OP_JUMP, R_MY, 8'h12, 8'h05, 12'h013, 5'd4, 1, ev(0,0,0,0,0,0), "jump_after_rst");
    step(0, OP_ADD, R_MY, 8'h00, 8'h05, 12'h014, 5'd4, 1, ev(1,1,0,0,0,0), "final_active");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: actual=stalled required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cell_divergence_ctrl.md
CELL_DIVERGENCE_CTRL -- requirements
Module: cell_divergence_ctrl

Interface
REQ-001 The block SHALL have parameter REGISTER_LENGTH, default 8, meaning the width of the target register value.
REQ-002 The block SHALL have parameter PC_LENGTH, default 12, meaning the program counter width.
REQ-003 The block SHALL have parameter SP_LENGTH, default 5, meaning the stack pointer width.
REQ-004 The block SHALL have parameter BRANCH_ADDR_BITS, default 8, range 1..12, meaning the branch target field width, instruction[BRANCH_ADDR_BITS-1:0].
REQ-005 The block SHALL have parameter DIV_CNT_WIDTH, default 8, meaning the divergence cycle counter width.
REQ-006 The block SHALL have parameter WATCHDOG_LIMIT, default 200, meaning the number of diverged cycles that triggers a fault; it SHALL satisfy 1 <= WATCHDOG_LIMIT <= 2^DIV_CNT_WIDTH-1.
REQ-007 Port clk: input, 1 bit, the single clock.
REQ-008 Port rst: input, 1 bit; reset is asynchronous and active-high.
REQ-009 Port target_value: input, REGISTER_LENGTH bits, the value of the instruction's target register.
REQ-010 Port instruction: input, 16 bits; opcode is [15:12] and target register is [11:8].
REQ-011 Port next_program_counter: input, PC_LENGTH bits, the globally agreed next PC.
REQ-012 Port next_stack_pointer: input, SP_LENGTH bits, the globally agreed next SP.
REQ-013 Port execution_enable: input, 1 bit, the global execute qualifier.
REQ-014 Port enable: output, 1 bit, permits a register write by this cell.
REQ-015 Port state_change_enable: output, 1 bit, permits a write to REG_MY.
REQ-016 Port diverge: output, 1 bit, this cell's vote against branch consensus.
REQ-017 Port div_state: output, 2 bits, encoded ACTIVE=0, DIVERGED=1, FAULT=2.
REQ-018 Port div_cycles: output, DIV_CNT_WIDTH bits, the length of the current or last divergence.
REQ-019 Port watchdog_err: output, 1 bit, sticky fault flag.

Function
REQ-020 The block SHALL compute cond_fail = (opcode==UNL) && (target_value==0) and btarget = instruction[BRANCH_ADDR_BITS-1:0], zero-extended to PC_LENGTH.
REQ-021 The block SHALL compute ujump = opcode in {JUMP, CALL, RET}.
REQ-022 The block SHALL drive diverge = (state==ACTIVE && cond_fail) || state!=ACTIVE.
REQ-023 The block SHALL drive enable = execution_enable && !diverge && !ujump, and state_change_enable = enable && target==REG_MY, both combinationally with zero latency.
REQ-024 In ACTIVE with cond_fail and next_program_counter==btarget, the block SHALL set local_pc<=btarget and remain in ACTIVE (consensus reached).
REQ-025 In ACTIVE with cond_fail and next_program_counter!=btarget, the block SHALL set local_pc<=btarget, latch rec_pc<=btarget and rec_sp<=local_sp, clear div_cycles to 0, and move to DIVERGED.
REQ-026 In ACTIVE without cond_fail, the block SHALL set local_pc<=next_program_counter and local_sp<=next_stack_pointer regardless of execution_enable.
REQ-027 In DIVERGED with next_program_counter==rec_pc and next_stack_pointer==rec_sp (full-width compare), the block SHALL move to ACTIVE at the next edge and hold div_cycles.
REQ-028 In DIVERGED otherwise, div_cycles SHALL increment by 1 per cycle, saturating at 2^DIV_CNT_WIDTH-1 without wrapping.
REQ-029 In DIVERGED, the block SHALL enter FAULT and set watchdog_err when div_cycles reaches WATCHDOG_LIMIT without a rejoin.
REQ-030 If rejoin and the limit coincide in the same cycle, rejoin SHALL win.
REQ-031 FAULT SHALL be terminal until rst, with enable=0 and diverge=1 so that other cells are not deadlocked.

Reset
REQ-032 On rst, the block SHALL asynchronously set state to ACTIVE, local_pc, local_sp, rec_pc, rec_sp and div_cycles to 0, and watchdog_err to 0.
REQ-033 With rst asserted, the outputs SHALL be: diverge = cond_fail, enable per REQ-023, div_state=0.
REQ-034 A reset applied mid-divergence or during FAULT SHALL abandon the state immediately, with no pending update surviving.

Configuration
REQ-035 With macro CELL_DIV_WATCHDOG_EN defined, REQ-029 through REQ-031 SHALL be compiled in.
REQ-036 Without CELL_DIV_WATCHDOG_EN, there SHALL be no FAULT state, watchdog_err SHALL be tied to 0, and DIVERGED SHALL persist until rejoin with div_cycles saturating.

Verification
REQ-037 The bench SHALL cover: UNL with target_value=0, btarget=0x20, next_pc=0x20 -> state stays ACTIVE, diverge=1 for one cycle, enable=0.
REQ-038 The bench SHALL cover: UNL with target_value=0, btarget=0x20, next_pc=0x05 -> DIVERGED; next_pc=0x20 with sp matching for one cycle -> ACTIVE at the next edge, and div_cycles equals the cycles spent.
REQ-039 The bench SHALL cover: in DIVERGED, next_pc=0x20 with a mismatched sp -> remains DIVERGED, then rejoins once sp matches.
REQ-040 The bench SHALL cover: CELL_DIV_WATCHDOG_EN defined, WATCHDOG_LIMIT=10, no rejoin -> FAULT after 10 diverged cycles, watchdog_err=1, diverge=1; rejoin arriving on cycle 10 -> ACTIVE instead.
REQ-041 The bench SHALL cover: DIV_CNT_WIDTH=4 with the macro undefined, diverged for 40 cycles -> div_cycles holds at 15.
REQ-042 The bench SHALL cover: rst pulsed asynchronously mid-DIVERGED -> div_state=0 and div_cycles=0 before the next clk edge; JUMP after reset -> enable=0, diverge=0.
